// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch stage, the upstream end of fetch->decode.
// Holds the PC, issues one-outstanding instruction-memory requests, buffers
// one word while decode is frozen, and applies decode's redirect requests.
// A request that is still in flight when a redirect arrives is allowed to
// finish and its data is thrown away (DROP state).
// Optional statistics counters are built when the macro FETCH_STATS_EN is
// defined; otherwise the three count ports are tied to zero.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        CLK,
  input  logic        RESET,
  output logic [31:0] IMem_Addr_OUT,
  output logic        IMem_Req_OUT,
  input  logic        IMem_Ack_IN,
  input  logic [31:0] IMem_Data_IN,
  input  logic [31:0] Alt_PC_IN,
  input  logic        Request_Alt_PC_IN,
  input  logic        WANT_FREEZE_IN,
  output logic [31:0] Instr1_OUT,
  output logic [31:0] Instr_PC_OUT,
  output logic [31:0] Instr_PC_Plus4_OUT,
  output logic [31:0] Fetch_Count_OUT,
  output logic [31:0] Bubble_Count_OUT,
  output logic [31:0] Redirect_Count_OUT
);

  localparam logic [0:0] FETCH = 1'b0;
  localparam logic [0:0] DROP  = 1'b1;

  logic [0:0]  state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] redir_pc, redir_pc_n;
  logic        buf_valid, buf_valid_n;
  logic [31:0] buf_instr, buf_instr_n;
  logic [31:0] buf_pc, buf_pc_n;
  logic [31:0] instr, instr_n;
  logic [31:0] instr_pc, instr_pc_n;
  logic [31:0] instr_pc4, instr_pc4_n;
  logic        ack_taken;
  logic [31:0] pc_plus4;

  // Memory side: request whenever the skid buffer has room and we are out of reset.
  assign IMem_Req_OUT  = !buf_valid && RESET;
  assign IMem_Addr_OUT = pc;
  assign ack_taken     = IMem_Ack_IN && IMem_Req_OUT;
  assign pc_plus4      = pc + 32'd4;

  assign Instr1_OUT         = instr;
  assign Instr_PC_OUT       = instr_pc;
  assign Instr_PC_Plus4_OUT = instr_pc4;

  // Next-state selection: redirect beats freeze, freeze beats delivery.
  always_comb begin
    state_n     = state;
    pc_n        = pc;
    redir_pc_n  = redir_pc;
    buf_valid_n = buf_valid;
    buf_instr_n = buf_instr;
    buf_pc_n    = buf_pc;
    instr_n     = instr;
    instr_pc_n  = instr_pc;
    instr_pc4_n = instr_pc4;
    case (state)
      FETCH: begin
        if (Request_Alt_PC_IN) begin
          instr_n     = 32'd0;
          buf_valid_n = 1'b0;
          if (IMem_Req_OUT && !IMem_Ack_IN) begin
            state_n    = DROP;
            redir_pc_n = Alt_PC_IN;
          end else begin
            pc_n = Alt_PC_IN;
          end
        end else if (WANT_FREEZE_IN) begin
          if (ack_taken) begin
            buf_valid_n = 1'b1;
            buf_instr_n = IMem_Data_IN;
            buf_pc_n    = pc;
            pc_n        = pc_plus4;
          end
        end else if (buf_valid) begin
          instr_n     = buf_instr;
          instr_pc_n  = buf_pc;
          instr_pc4_n = buf_pc + 32'd4;
          buf_valid_n = 1'b0;
        end else if (ack_taken) begin
          instr_n     = IMem_Data_IN;
          instr_pc_n  = pc;
          instr_pc4_n = pc_plus4;
          pc_n        = pc_plus4;
        end else begin
          instr_n = 32'd0;
        end
      end
      default: begin
        if (Request_Alt_PC_IN) begin
          redir_pc_n = Alt_PC_IN;
        end
        if (ack_taken) begin
          pc_n    = Request_Alt_PC_IN ? Alt_PC_IN : redir_pc;
          state_n = FETCH;
        end
        if (!WANT_FREEZE_IN) begin
          instr_n = 32'd0;
        end
      end
    endcase
  end

  // Register update with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      redir_pc  <= 32'd0;
      buf_valid <= 1'b0;
      buf_instr <= 32'd0;
      buf_pc    <= 32'd0;
      instr     <= 32'd0;
      instr_pc  <= 32'd0;
      instr_pc4 <= 32'd0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      redir_pc  <= redir_pc_n;
      buf_valid <= buf_valid_n;
      buf_instr <= buf_instr_n;
      buf_pc    <= buf_pc_n;
      instr     <= instr_n;
      instr_pc  <= instr_pc_n;
      instr_pc4 <= instr_pc4_n;
    end
  end

`ifdef FETCH_STATS_EN
  logic        deliver_evt, bubble_evt, redirect_evt;
  logic [31:0] fetch_cnt, bubble_cnt, redirect_cnt;

  assign deliver_evt  = (state == FETCH) && !Request_Alt_PC_IN && !WANT_FREEZE_IN &&
                        (buf_valid || ack_taken);
  assign bubble_evt   = ((state == FETCH) && (Request_Alt_PC_IN ||
                         (!WANT_FREEZE_IN && !buf_valid && !ack_taken))) ||
                        ((state == DROP) && !WANT_FREEZE_IN);
  assign redirect_evt = Request_Alt_PC_IN;

  // Saturating event counters for delivered words, bubbles and redirects.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      fetch_cnt    <= 32'd0;
      bubble_cnt   <= 32'd0;
      redirect_cnt <= 32'd0;
    end else begin
      if (deliver_evt && (fetch_cnt != 32'hFFFF_FFFF)) begin
        fetch_cnt <= fetch_cnt + 32'd1;
      end
      if (bubble_evt && (bubble_cnt != 32'hFFFF_FFFF)) begin
        bubble_cnt <= bubble_cnt + 32'd1;
      end
      if (redirect_evt && (redirect_cnt != 32'hFFFF_FFFF)) begin
        redirect_cnt <= redirect_cnt + 32'd1;
      end
    end
  end

  assign Fetch_Count_OUT    = fetch_cnt;
  assign Bubble_Count_OUT   = bubble_cnt;
  assign Redirect_Count_OUT = redirect_cnt;
`else
  assign Fetch_Count_OUT    = 32'd0;
  assign Bubble_Count_OUT   = 32'd0;
  assign Redirect_Count_OUT = 32'd0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed vector table, wrap-around instance, random traffic
// against a queue-based reference model, and an asynchronous mid-request reset.
module tb_instr_fetch;

  localparam logic [31:0] RESET_PC = 32'h0040_0000;
  localparam logic [31:0] WRAP_PC  = 32'hFFFF_FFFC;
  localparam int NUM_VECS = 21;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic [31:0] alt_pc;
  logic        redir;
  logic        freeze;
  logic [31:0] instr, instr_pc, instr_pc4;
  logic [31:0] fetch_cnt, bubble_cnt, redirect_cnt;

  logic [31:0] w_addr, w_data, w_instr, w_pc, w_pc4;
  logic        w_req;
  logic [31:0] w_fc, w_bc, w_rc;

  int pass_cnt = 0;
  int total_cnt = 0;

  instr_fetch #(.RESET_PC(RESET_PC)) dut (
    .CLK(clk), .RESET(rst_n),
    .IMem_Addr_OUT(imem_addr), .IMem_Req_OUT(imem_req),
    .IMem_Ack_IN(imem_ack), .IMem_Data_IN(imem_data),
    .Alt_PC_IN(alt_pc), .Request_Alt_PC_IN(redir), .WANT_FREEZE_IN(freeze),
    .Instr1_OUT(instr), .Instr_PC_OUT(instr_pc), .Instr_PC_Plus4_OUT(instr_pc4),
    .Fetch_Count_OUT(fetch_cnt), .Bubble_Count_OUT(bubble_cnt),
    .Redirect_Count_OUT(redirect_cnt)
  );

  // Second instance with a zero-wait memory, used for the PC wrap case.
  assign w_data = w_addr ^ 32'h0000_1000;

  instr_fetch #(.RESET_PC(WRAP_PC)) u_wrap (
    .CLK(clk), .RESET(rst_n),
    .IMem_Addr_OUT(w_addr), .IMem_Req_OUT(w_req),
    .IMem_Ack_IN(1'b1), .IMem_Data_IN(w_data),
    .Alt_PC_IN(32'h0), .Request_Alt_PC_IN(1'b0), .WANT_FREEZE_IN(1'b0),
    .Instr1_OUT(w_instr), .Instr_PC_OUT(w_pc), .Instr_PC_Plus4_OUT(w_pc4),
    .Fetch_Count_OUT(w_fc), .Bubble_Count_OUT(w_bc), .Redirect_Count_OUT(w_rc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
  } fetched_t;

  fetched_t    skid[$];
  logic [31:0] m_pc, m_target;
  logic        m_stale;
  logic [31:0] m_instr, m_ipc, m_ipc4;
  logic [31:0] m_fetches, m_bubbles, m_redirects;

  function automatic logic [31:0] satInc(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction

  function automatic logic [31:0] expCount(input logic [31:0] c);
`ifdef FETCH_STATS_EN
    return c;
`else
    return (c & 32'd0);
`endif
  endfunction

  task automatic modelReset();
    skid.delete();
    m_pc = RESET_PC; m_target = 32'd0; m_stale = 1'b0;
    m_instr = 32'd0; m_ipc = 32'd0; m_ipc4 = 32'd0;
    m_fetches = 32'd0; m_bubbles = 32'd0; m_redirects = 32'd0;
  endtask

  task automatic emitBubble();
    m_instr = 32'd0;
    m_bubbles = satInc(m_bubbles);
  endtask

  task automatic emitWord(input logic [31:0] w, input logic [31:0] p);
    m_instr = w; m_ipc = p; m_ipc4 = p + 32'd4;
    m_fetches = satInc(m_fetches);
  endtask

  function automatic logic modelReq();
    return rst_n && (skid.size() == 0);
  endfunction

  task automatic modelStep();
    logic taken;
    fetched_t f;
    if (!rst_n) begin
      modelReset();
    end else begin
      taken = modelReq() && imem_ack;
      if (redir) m_redirects = satInc(m_redirects);
      if (m_stale) begin
        if (redir) m_target = alt_pc;
        if (taken) begin
          m_pc = m_target;
          m_stale = 1'b0;
        end
        if (!freeze) emitBubble();
      end else if (redir) begin
        if (modelReq() && !taken) begin
          m_stale = 1'b1;
          m_target = alt_pc;
        end else begin
          m_pc = alt_pc;
        end
        skid.delete();
        emitBubble();
      end else if (freeze) begin
        if (taken) begin
          skid.push_back('{imem_data, m_pc});
          m_pc = m_pc + 32'd4;
        end
      end else if (skid.size() != 0) begin
        f = skid.pop_front();
        emitWord(f.word, f.pc);
      end else if (taken) begin
        emitWord(imem_data, m_pc);
        m_pc = m_pc + 32'd4;
      end else begin
        emitBubble();
      end
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total_cnt++;
    if (actual === expected) begin
      pass_cnt++;
    end else begin
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic checkModel();
    checkOutput("model req", 32'(imem_req), 32'(modelReq()));
    checkOutput("model addr", imem_addr, m_pc);
    checkOutput("model instr", instr, m_instr);
    checkOutput("model pc", instr_pc, m_ipc);
    checkOutput("model pc4", instr_pc4, m_ipc4);
    checkOutput("model fetch_cnt", fetch_cnt, expCount(m_fetches));
    checkOutput("model bubble_cnt", bubble_cnt, expCount(m_bubbles));
    checkOutput("model redirect_cnt", redirect_cnt, expCount(m_redirects));
  endtask

  task automatic applyStimulus(input logic ack, input logic [31:0] data, input logic rd,
                               input logic [31:0] alt, input logic frz);
    imem_ack = ack; imem_data = data; redir = rd; alt_pc = alt; freeze = frz;
  endtask

  // One clock: edge, model update, compare, then return just after the negedge.
  task automatic stepCycle();
    @(posedge clk);
    modelStep();
    #1;
    checkModel();
    @(negedge clk);
    #1;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic        ack;
    logic [31:0] data;
    logic        rd;
    logic [31:0] alt;
    logic        frz;
    logic [31:0] exp_instr;
    logic [31:0] exp_pc;
    logic [31:0] exp_addr;
    logic        exp_req;
  } vec_t;

  vec_t vecs[NUM_VECS];

  int mem_cnt, mem_wait, freeze_left;

  task automatic randomCycle();
    logic req_now, a, rd, frz;
    logic [31:0] d, alt;
    req_now = modelReq();
    a = req_now ? (mem_cnt >= mem_wait) : ($urandom_range(0, 3) == 0);
    d = (req_now && a) ? (m_pc ^ 32'h0000_1000) : $urandom;
    rd = ($urandom_range(0, 9) == 0);
    alt = RESET_PC + 32'($urandom_range(0, 4095));
    if (freeze_left > 0) begin
      frz = 1'b1;
      freeze_left--;
    end else if ($urandom_range(0, 7) == 0) begin
      frz = 1'b1;
      freeze_left = $urandom_range(0, 3);
    end else begin
      frz = 1'b0;
    end
    applyStimulus(a, d, rd, alt, frz);
    stepCycle();
    if (req_now && a) begin
      mem_cnt = 0;
      mem_wait = $urandom_range(0, 3);
    end else if (req_now) begin
      mem_cnt++;
    end
  endtask

  initial begin
    vecs[0]  = '{1'b1, 32'h0040_1000, 1'b0, 32'h0, 1'b0, 32'h0040_1000, 32'h0040_0000, 32'h0040_0004, 1'b1};
    vecs[1]  = '{1'b1, 32'h0040_1004, 1'b0, 32'h0, 1'b0, 32'h0040_1004, 32'h0040_0004, 32'h0040_0008, 1'b1};
    vecs[2]  = '{1'b1, 32'h0040_1008, 1'b0, 32'h0, 1'b0, 32'h0040_1008, 32'h0040_0008, 32'h0040_000C, 1'b1};
    vecs[3]  = '{1'b0, 32'h0,         1'b0, 32'h0, 1'b0, 32'h0,         32'h0040_0008, 32'h0040_000C, 1'b1};
    vecs[4]  = '{1'b0, 32'h0,         1'b0, 32'h0, 1'b0, 32'h0,         32'h0040_0008, 32'h0040_000C, 1'b1};
    vecs[5]  = '{1'b1, 32'h0040_100C, 1'b0, 32'h0, 1'b0, 32'h0040_100C, 32'h0040_000C, 32'h0040_0010, 1'b1};
    vecs[6]  = '{1'b1, 32'h0040_1010, 1'b1, 32'h0040_0100, 1'b0, 32'h0, 32'h0040_000C, 32'h0040_0100, 1'b1};
    vecs[7]  = '{1'b1, 32'h0040_1100, 1'b0, 32'h0, 1'b0, 32'h0040_1100, 32'h0040_0100, 32'h0040_0104, 1'b1};
    vecs[8]  = '{1'b0, 32'h0,         1'b1, 32'h0040_0300, 1'b0, 32'h0, 32'h0040_0100, 32'h0040_0104, 1'b1};
    vecs[9]  = '{1'b0, 32'h0,         1'b1, 32'h0040_0200, 1'b0, 32'h0, 32'h0040_0100, 32'h0040_0104, 1'b1};
    vecs[10] = '{1'b1, 32'h0040_1104, 1'b0, 32'h0, 1'b0, 32'h0,         32'h0040_0100, 32'h0040_0200, 1'b1};
    vecs[11] = '{1'b1, 32'h0040_1200, 1'b0, 32'h0, 1'b0, 32'h0040_1200, 32'h0040_0200, 32'h0040_0204, 1'b1};
    vecs[12] = '{1'b1, 32'h0040_1204, 1'b0, 32'h0, 1'b1, 32'h0040_1200, 32'h0040_0200, 32'h0040_0208, 1'b0};
    vecs[13] = '{1'b1, 32'hDEAD_0000, 1'b0, 32'h0, 1'b1, 32'h0040_1200, 32'h0040_0200, 32'h0040_0208, 1'b0};
    vecs[14] = '{1'b0, 32'h0,         1'b0, 32'h0, 1'b1, 32'h0040_1200, 32'h0040_0200, 32'h0040_0208, 1'b0};
    vecs[15] = '{1'b0, 32'h0,         1'b0, 32'h0, 1'b1, 32'h0040_1200, 32'h0040_0200, 32'h0040_0208, 1'b0};
    vecs[16] = '{1'b1, 32'hBAD0_0000, 1'b0, 32'h0, 1'b0, 32'h0040_1204, 32'h0040_0204, 32'h0040_0208, 1'b1};
    vecs[17] = '{1'b1, 32'h0040_1208, 1'b0, 32'h0, 1'b0, 32'h0040_1208, 32'h0040_0208, 32'h0040_020C, 1'b1};
    vecs[18] = '{1'b1, 32'h0040_120C, 1'b0, 32'h0, 1'b1, 32'h0040_1208, 32'h0040_0208, 32'h0040_0210, 1'b0};
    vecs[19] = '{1'b0, 32'h0,         1'b1, 32'h0040_0400, 1'b1, 32'h0, 32'h0040_0208, 32'h0040_0400, 1'b1};
    vecs[20] = '{1'b1, 32'h0040_1400, 1'b0, 32'h0, 1'b0, 32'h0040_1400, 32'h0040_0400, 32'h0040_0404, 1'b1};

    // Reset held low for three cycles.
    rst_n = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    #1 rst_n = 1'b0;
    modelReset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("reset req", 32'(imem_req), 32'd0);
    checkOutput("reset addr", imem_addr, RESET_PC);
    checkOutput("reset instr", instr, 32'd0);
    checkOutput("reset pc", instr_pc, 32'd0);
    checkOutput("reset pc4", instr_pc4, 32'd0);
    checkOutput("reset fetch_cnt", fetch_cnt, 32'd0);
    checkOutput("reset bubble_cnt", bubble_cnt, 32'd0);
    checkOutput("reset redirect_cnt", redirect_cnt, 32'd0);
    rst_n = 1'b1;
    #1;
    checkOutput("release req", 32'(imem_req), 32'd1);
    checkOutput("release addr", imem_addr, RESET_PC);
    checkOutput("wrap first addr", w_addr, WRAP_PC);

    // Directed table: stream, wait states, redirects, DROP, freeze, squash.
    for (int i = 0; i < NUM_VECS; i++) begin
      applyStimulus(vecs[i].ack, vecs[i].data, vecs[i].rd, vecs[i].alt, vecs[i].frz);
      stepCycle();
      checkOutput($sformatf("vec%0d instr", i), instr, vecs[i].exp_instr);
      checkOutput($sformatf("vec%0d pc", i), instr_pc, vecs[i].exp_pc);
      checkOutput($sformatf("vec%0d pc4", i), instr_pc4, vecs[i].exp_pc + 32'd4);
      checkOutput($sformatf("vec%0d addr", i), imem_addr, vecs[i].exp_addr);
      checkOutput($sformatf("vec%0d req", i), 32'(imem_req), 32'(vecs[i].exp_req));
      if (i == 0) begin
        checkOutput("wrap instr0", w_instr, 32'hFFFF_EFFC);
        checkOutput("wrap pc0", w_pc, WRAP_PC);
        checkOutput("wrap pc4_0", w_pc4, 32'd0);
        checkOutput("wrap addr1", w_addr, 32'd0);
      end
      if (i == 1) begin
        checkOutput("wrap instr1", w_instr, 32'h0000_1000);
        checkOutput("wrap pc1", w_pc, 32'd0);
        checkOutput("wrap pc4_1", w_pc4, 32'd4);
        checkOutput("wrap req", 32'(w_req), 32'd1);
        checkOutput("wrap fetch_cnt", w_fc, expCount(32'd2));
        checkOutput("wrap bubble_cnt", w_bc, 32'd0);
        checkOutput("wrap redirect_cnt", w_rc, 32'd0);
      end
    end
    checkOutput("table fetch_cnt", fetch_cnt, expCount(32'd9));
    checkOutput("table bubble_cnt", bubble_cnt, expCount(32'd7));
    checkOutput("table redirect_cnt", redirect_cnt, expCount(32'd4));

    // Random traffic against the reference model.
    mem_cnt = 0;
    mem_wait = $urandom_range(0, 3);
    freeze_left = 0;
    for (int c = 0; c < 1500; c++) begin
      randomCycle();
    end

    // Asynchronous reset in the middle of a pending request.
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("async reset req", 32'(imem_req), 32'd0);
    checkOutput("async reset addr", imem_addr, RESET_PC);
    checkOutput("async reset instr", instr, 32'd0);
    checkOutput("async reset fetch_cnt", fetch_cnt, 32'd0);
    checkOutput("async reset bubble_cnt", bubble_cnt, 32'd0);
    @(posedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    mem_cnt = 0;
    mem_wait = $urandom_range(0, 3);
    freeze_left = 0;
    for (int c = 0; c < 200; c++) begin
      randomCycle();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

- Instruction fetch stage; the upstream end of the fetch→decode interface.
- Holds the PC and issues one-outstanding instruction-memory requests.
- Presents fetched words with their PC and PC+4 to decode, and applies decode's registered branch/jump redirect and freeze requests.
- Bubbles are delivered as instruction word 0 (nop); decode has no separate valid signal.

## Interface
Parameters:
- RESET_PC, 32'h0040_0000, PC loaded at reset (first fetch address)

Ports:
- CLK  in  1  clock, all state on rising edge
- RESET  in  1  asynchronous, active-low reset
- IMem_Addr_OUT  out  32  fetch address (combinational from PC register)
- IMem_Req_OUT  out  1  fetch request
- IMem_Ack_IN  in  1  memory returns IMem_Data_IN this cycle
- IMem_Data_IN  in  32  instruction word, valid with ack
- Alt_PC_IN  in  32  redirect target from decode
- Request_Alt_PC_IN  in  1  redirect strobe from decode (registered there, one-cycle pulse)
- WANT_FREEZE_IN  in  1  decode requests hold of its input
- Instr1_OUT  out  32  instruction to decode (0 = bubble)
- Instr_PC_OUT  out  32  PC of Instr1_OUT
- Instr_PC_Plus4_OUT  out  32  Instr_PC_OUT+4
- Fetch_Count_OUT  out  32  instructions delivered (see Configuration)
- Bubble_Count_OUT  out  32  bubble cycles delivered
- Redirect_Count_OUT  out  32  redirects accepted

## Operation
Memory handshake:
- IMem_Req_OUT = (!buf_valid) && RESET.
- IMem_Addr_OUT = PC.
- Addr is held stable until an ack is sampled at a rising edge.
- Ack may arrive in the same cycle as Req (zero-wait memory gives back-to-back fetches).
- Ack while Req=0 is ignored.

States:
- FETCH: normal operation.
- DROP: an in-flight request is stale and its returned data will be discarded.

FETCH, per rising edge (conditions checked in priority order):
- **Redirect, ack same cycle:** data discarded, PC<=Alt_PC_IN, buf_valid<=0, Instr1_OUT<=0.
- **Redirect, Req high, no ack:** state<=DROP, redir_pc<=Alt_PC_IN, buf_valid<=0, Instr1_OUT<=0.
- **Redirect, Req low (buffer full):** buffer squashed, PC<=Alt_PC_IN, Instr1_OUT<=0.
- **WANT_FREEZE_IN=1:** all decode outputs hold.
  - An ack in this cycle writes the word and its PC into the 1-entry skid buffer (buf_valid<=1) and advances PC<=PC+4.
- **Not frozen, buf_valid=1:** buffer content goes to decode outputs, buf_valid<=0.
  - An ack cannot coincide with this, because Req is low while buf_valid=1.
- **Not frozen, ack:** Instr1_OUT<=IMem_Data_IN, Instr_PC_OUT<=PC, Instr_PC_Plus4_OUT<=PC+4, PC<=PC+4.
- **Not frozen, no ack:** Instr1_OUT<=0; Instr_PC_OUT and Instr_PC_Plus4_OUT hold.

DROP:
- Req stays high at the stale Addr.
- On ack: data discarded, PC<=redir_pc, state<=FETCH.
- A further redirect while in DROP overwrites redir_pc (latest wins). If that redirect coincides with the ack, the new Alt_PC_IN is used.
- Instr1_OUT<=0 every cycle unless WANT_FREEZE_IN=1, in which case outputs hold.

Arithmetic:
- PC+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- No alignment check; the low 2 bits are passed through unchanged.

Delay slot:
- Decode's redirect arrives one cycle after the branch leaves decode, so the delay-slot instruction has already been delivered.
- The word fetched during the redirect cycle is wrong-path and is always discarded per the rules above.

## Timing
- Reset (asynchronous): PC=RESET_PC, state=FETCH, buf_valid=0, redir_pc=0, all registered outputs and counters 0.
- IMem_Req_OUT=0 while RESET=0. It rises combinationally when RESET deasserts, with Addr=RESET_PC.
- Latency is ack edge → Instr1_OUT valid: 1 cycle (same edge that samples the ack).
- Redirect latency is pulse edge → target requested:
  - 0 cycles if there is no in-flight request or the ack coincides;
  - otherwise 1 cycle after the stale ack.
- Freeze releases in the cycle WANT_FREEZE_IN falls. The buffered word appears at the next edge, and Req reasserts the cycle after.
- Reset asserted mid-request: the in-flight request is abandoned. Memory must drop it on Req=0.

## Configuration
- FETCH_STATS_EN defined:
  - Fetch_Count_OUT increments on each edge delivering a non-bubble word (from memory or the buffer).
  - Bubble_Count_OUT increments on each edge writing Instr1_OUT<=0.
  - Redirect_Count_OUT increments on each accepted Request_Alt_PC_IN pulse.
  - All three saturate at 32'hFFFF_FFFF.
- Not defined: all three ports tied to 0 and no counter flops are built. Fetch behaviour is identical in both builds.

## Test plan
- **Reset/stream:** RESET low 3 cycles then high, zero-wait memory returning addr^32'h1000 → Addr 0x00400000, 0x00400004, … each cycle; Instr1_OUT/Instr_PC_OUT/Instr_PC_Plus4_OUT match one edge after each ack.
- **Wait states:** ack delayed 2 cycles per request → Addr stable while Req high; two Instr1_OUT=0 bubbles between words; Bubble_Count_OUT=2 per word with FETCH_STATS_EN.
- **Redirect with coincident ack:** pulse Request_Alt_PC_IN with Alt_PC_IN=0x00400100 while the ack for 0x00400010 lands → that word never reaches decode; next Addr=0x00400100; Redirect_Count_OUT=1.
- **Redirect into DROP:** pulse while a 3-wait request is pending, then a second pulse with 0x00400200 before the ack → stale data dropped; next Addr=0x00400200.
- **Freeze:** hold WANT_FREEZE_IN 4 cycles with an ack in the first → outputs frozen, Req low after buffering; on release the buffered word appears once, in order, with no loss or duplication.
- **Wrap:** RESET_PC=32'hFFFF_FFFC → second fetch Addr=0; Instr_PC_Plus4_OUT=0 for the first word.
